column_rasterizer: RTL and testbench

- Sits between the DDA-out FIFO and the frame buffer.
- Pops one ray result per screen column: column index, wall type, hit side and projected line height.
- Expands each result into a full vertical strip of ceiling, wall and floor pixels, at one frame-buffer write per clock.
- Flags the final pixel of the frame-closing column so the frame buffer can swap banks.

---
 rtl/column_rasterizer.sv | 203 ++++++++++++++++++++
 tb/tb_column_rasterizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_rasterizer.sv
`default_nettype none
// ============================================================================
// Module      : column_rasterizer
// Description : Pops one ray result per screen column from the DDA-out FIFO
//               and expands it into a vertical strip of ceiling, wall and
//               floor pixels, one frame-buffer write per clock. The last
//               pixel of a frame-closing column is flagged for bank swap.
//               Optional macro SIDE_SHADE_EN halves wall pixels of side=1
//               columns.
// Revision    : 1.0 - initial release
// ============================================================================
module column_rasterizer #(
  parameter int          SCREEN_W    = 320,
  parameter int          SCREEN_H    = 180,
  parameter logic [15:0] CEIL_COLOR  = 16'h18E3,
  parameter logic [15:0] FLOOR_COLOR = 16'h4208
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        dda_fifo_tvalid_in,
  input  logic [38:0] dda_fifo_tdata_in,
  input  logic        dda_fifo_tlast_in,
  output logic        transformer_tready_out,
  output logic [15:0] ray_address_out,
  output logic [15:0] ray_pixel_out,
  output logic        ray_valid_out,
  output logic        ray_last_pixel_out
);

  localparam int              c_YW     = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(SCREEN_H - 1);
  localparam logic [9:0]      c_H10    = 10'(SCREEN_H);
  localparam logic [9:0]      c_H_HALF = 10'(SCREEN_H / 2);
  localparam logic [9:0]      c_W10    = 10'(SCREEN_W);
  localparam logic [15:0]     c_W16    = 16'(SCREEN_W);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_t;

  // Incoming ray word fields
  logic [8:0]  w_in_col;
  logic [3:0]  w_in_type;
  logic        w_in_side;
  logic [8:0]  w_in_lh;
  logic [9:0]  w_in_lh10;
  logic        w_in_col_ok;
  logic [9:0]  w_in_start;
  logic [9:0]  w_in_stop;
  logic [15:0] w_in_wall;
  logic        w_unused;

  assign w_in_col    = dda_fifo_tdata_in[38:30];
  assign w_in_type   = dda_fifo_tdata_in[29:26];
  assign w_in_side   = dda_fifo_tdata_in[25];
  assign w_in_lh     = dda_fifo_tdata_in[24:16];
  assign w_in_lh10   = {1'b0, w_in_lh};
  assign w_in_col_ok = ({1'b0, w_in_col} < c_W10);

`ifdef SIDE_SHADE_EN
  assign w_unused = &{1'b0, dda_fifo_tdata_in[15:0]};
`else
  assign w_unused = &{1'b0, dda_fifo_tdata_in[15:0], w_in_side};
`endif

  // Per-column state
  state_t            r_state;
  logic              r_tready;
  logic              r_valid;
  logic              r_last;
  logic [15:0]       r_addr;
  logic [15:0]       r_pixel;
  logic [c_YW-1:0]   r_y;
  logic [9:0]        r_start;
  logic [9:0]        r_stop;
  logic [15:0]       r_wall;
  logic              r_tlast;
  logic              r_col_ok;

  // Vertical wall span of the incoming word; an empty column is expressed as
  // an inverted span centred on the horizon so the pixel select needs no flag.
  always_comb begin
    w_in_start = '0;
    w_in_stop  = c_H10 - 10'd1;
    if ((w_in_lh == 9'd0) || (w_in_type == 4'd0)) begin
      w_in_start = c_H_HALF;
      w_in_stop  = c_H_HALF - 10'd1;
    end else if (w_in_lh10 >= c_H10) begin
      w_in_start = '0;
      w_in_stop  = c_H10 - 10'd1;
    end else begin
      w_in_start = (c_H10 - w_in_lh10) >> 1;
      w_in_stop  = w_in_start + w_in_lh10 - 10'd1;
    end
  end

  // Wall palette lookup from wall type, with optional side shading
  always_comb begin
    logic [4:0] v_r;
    logic [5:0] v_g;
    logic [4:0] v_b;
    v_r = w_in_type[0] ? 5'h1F : 5'h04;
    v_g = w_in_type[1] ? 6'h3F : 6'h08;
    v_b = w_in_type[2] ? 5'h1F : 5'h04;
    if (w_in_type[3]) begin
      v_r = v_r >> 1;
      v_g = v_g >> 1;
      v_b = v_b >> 1;
    end
`ifdef SIDE_SHADE_EN
    if (w_in_side) begin
      v_r = v_r >> 1;
      v_g = v_g >> 1;
      v_b = v_b >> 1;
    end
`endif
    w_in_wall = {v_r, v_g, v_b};
  end

  function automatic logic [15:0] f_pixel(input logic [9:0]  y,
                                          input logic [9:0]  start,
                                          input logic [9:0]  stop,
                                          input logic [15:0] wall);
    if (y < start) begin
      f_pixel = CEIL_COLOR;
    end else if (y > stop) begin
      f_pixel = FLOOR_COLOR;
    end else begin
      f_pixel = wall;
    end
  endfunction

  // Column FSM: accept a word in IDLE, then stream SCREEN_H registered pixels
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_tready <= 1'b1;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_addr   <= '0;
      r_pixel  <= '0;
      r_y      <= '0;
      r_start  <= '0;
      r_stop   <= '0;
      r_wall   <= '0;
      r_tlast  <= 1'b0;
      r_col_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dda_fifo_tvalid_in) begin
            r_state  <= S_DRAW;
            r_tready <= 1'b0;
            r_start  <= w_in_start;
            r_stop   <= w_in_stop;
            r_wall   <= w_in_wall;
            r_tlast  <= dda_fifo_tlast_in;
            r_col_ok <= w_in_col_ok;
            // Row 0 goes out on the very next cycle
            r_y      <= '0;
            r_addr   <= {7'd0, w_in_col};
            r_pixel  <= f_pixel(10'd0, w_in_start, w_in_stop, w_in_wall);
            r_valid  <= w_in_col_ok;
            r_last   <= dda_fifo_tlast_in && (c_Y_LAST == '0);
          end
        end
        S_DRAW: begin
          if (r_y == c_Y_LAST) begin
            r_state  <= S_IDLE;
            r_tready <= 1'b1;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_addr   <= '0;
            r_pixel  <= '0;
          end else begin
            // Address steps by one row; off-screen columns keep timing but
            // never qualify a write, while the frame-end flag still fires
            r_y      <= r_y + 1'b1;
            r_addr   <= r_addr + c_W16;
            r_pixel  <= f_pixel(10'(r_y + 1'b1), r_start, r_stop, r_wall);
            r_valid  <= r_col_ok;
            r_last   <= r_tlast && ((r_y + 1'b1) == c_Y_LAST);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tready <= 1'b1;
          r_valid  <= 1'b0;
          r_last   <= 1'b0;
        end
      endcase
    end
  end

  assign transformer_tready_out = r_tready;
  assign ray_address_out        = r_addr;
  assign ray_pixel_out          = r_pixel;
  assign ray_valid_out          = r_valid;
  assign ray_last_pixel_out     = r_last;

endmodule
`default_nettype wire

// File: tb/tb_column_rasterizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_rasterizer
// Description : Scoreboard bench for column_rasterizer. Expected writes are
//               queued when a ray word is driven and popped as the DUT emits
//               them. Honours SIDE_SHADE_EN for the expected wall colour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_column_rasterizer;

  localparam int          W     = 320;
  localparam int          H     = 180;
  localparam logic [15:0] CEIL  = 16'h18E3;
  localparam logic [15:0] FLOOR = 16'h4208;
`ifdef SIDE_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic [38:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [15:0] addr;
  logic [15:0] pix;
  logic        valid;
  logic        lastp;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int orphan_seen = 0;
  int orphan_exp = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_e;

  column_rasterizer #(
    .SCREEN_W(W), .SCREEN_H(H), .CEIL_COLOR(CEIL), .FLOOR_COLOR(FLOOR)
  ) u_dut (
    .pixel_clk_in          (clk),
    .rst_in                (rst),
    .dda_fifo_tvalid_in    (tvalid),
    .dda_fifo_tdata_in     (tdata),
    .dda_fifo_tlast_in     (tlast),
    .transformer_tready_out(tready),
    .ray_address_out       (addr),
    .ray_pixel_out         (pix),
    .ray_valid_out         (valid),
    .ray_last_pixel_out    (lastp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference pixel straight from the span and palette rules
  function automatic logic [15:0] exp_pix(input int y, input int lh, input int typ, input bit side);
    int s, e;
    logic [4:0] r, b;
    logic [5:0] g;
    if (lh == 0 || typ == 0) return (y < H / 2) ? CEIL : FLOOR;
    if (lh >= H) begin
      s = 0;
      e = H - 1;
    end else begin
      s = (H - lh) / 2;
      e = s + lh - 1;
    end
    if (y < s) return CEIL;
    if (y > e) return FLOOR;
    r = typ[0] ? 5'h1F : 5'h04;
    g = typ[1] ? 6'h3F : 6'h08;
    b = typ[2] ? 5'h1F : 5'h04;
    if (typ[3]) begin r = r / 2; g = g / 2; b = b / 2; end
    if (SHADE && side) begin r = r / 2; g = g / 2; b = b / 2; end
    return {r, g, b};
  endfunction

  task automatic push_model(input int col, input int lh, input int typ, input bit side, input bit last);
    for (int y = 0; y < H; y++) begin
      if (col < W) sb.push_back({(last && (y == H - 1)), 16'(y * W + col), exp_pix(y, lh, typ, side)});
    end
    if (col >= W && last) orphan_exp++;
  endtask

  // Caller sits at a negedge; returns at the negedge after the handshake edge
  task automatic send(input int col, input int typ, input bit side, input int lh,
                      input bit last, input bit hold, output int acc);
    int guard;
    logic [8:0] c9, l9;
    logic [3:0] t4;
    c9 = col[8:0];
    l9 = lh[8:0];
    t4 = typ[3:0];
    tdata  = {c9, t4, side, l9, 16'hA5A5};
    tlast  = last;
    tvalid = 1'b1;
    guard  = 0;
    while (tready !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) chk("tready_timeout", 32'd0, 32'd1);
    push_model(col, lh, typ, side, last);
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    if (!hold) begin
      tvalid = 1'b0;
      tdata  = 39'($urandom());
      tlast  = 1'b1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every qualified write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", {16'h0, addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("addr", {16'h0, addr}, {16'h0, mon_e[31:16]});
          chk("pixel", {16'h0, pix}, {16'h0, mon_e[15:0]});
          chk("last", {31'h0, lastp}, {31'h0, mon_e[32]});
        end
      end else if (lastp === 1'b1) begin
        orphan_seen++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, low;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_tready", {31'h0, tready}, 32'd1);
    chk("rst_valid", {31'h0, valid}, 32'd0);
    chk("rst_last", {31'h0, lastp}, 32'd0);
    chk("rst_addr", {16'h0, addr}, 32'd0);
    chk("rst_pixel", {16'h0, pix}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic column: ceiling / wall F904 / floor, ends at 57285
    send(5, 1, 1'b0, 60, 1'b0, 1'b0, a1);
    low = 0;
    for (int i = 0; i < H; i++) begin
      if (tready === 1'b0) low++;
      @(negedge clk);
    end
    chk("tready_low_cycles", low, H);
    chk("tready_back", {31'h0, tready}, 32'd1);
    chk("valid_gap", {31'h0, valid}, 32'd0);
    drain();

    // Tall wall, last column of frame
    send(319, 1, 1'b0, 200, 1'b1, 1'b0, a1);
    drain();
    // Empty columns: zero height, and zero wall type
    send(17, 7, 1'b0, 0, 1'b0, 1'b0, a1);
    drain();
    send(18, 0, 1'b0, 100, 1'b0, 1'b0, a1);
    drain();
    // Halved palette with odd height
    send(100, 14, 1'b0, 33, 1'b0, 1'b0, a1);
    drain();

    // Back-to-back with tvalid held
    send(20, 3, 1'b0, 120, 1'b0, 1'b1, a1);
    send(21, 6, 1'b0, 179, 1'b0, 1'b0, a2);
    chk("b2b_spacing", a2 - a1, H + 1);
    drain();

    // Off-screen column with tlast: no writes, frame flag still pulses
    send(400, 1, 1'b0, 60, 1'b1, 1'b0, a1);
    repeat (H + 5) @(negedge clk);
    chk("orphan_last", orphan_seen, orphan_exp);
    chk("offscreen_no_writes", sb.size(), 0);

    // Reset while row 100 is on the outputs
    send(30, 2, 1'b0, 100, 1'b1, 1'b0, a1);
    repeat (100) @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", {31'h0, valid}, 32'd0);
    chk("midrst_tready", {31'h0, tready}, 32'd1);
    chk("midrst_last", {31'h0, lastp}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(31, 9, 1'b0, 150, 1'b0, 1'b0, a1);
    drain();

    // Side-shaded wall
    send(40, 1, 1'b1, 60, 1'b0, 1'b0, a1);
    drain();

    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_orphan", orphan_seen, orphan_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
